cmpl_mult_acc: RTL
==================

Name: cmpl_mult_acc

Overview:
Parametrised complex multiplier with an optional per-frame complex accumulator (dot-product / correlator tap), an optional conjugate on operand B, and rounding and saturation of the output. It sits in the DSP datapath after complex sources (mixers, FFT bins) and feeds fixed-width downstream logic. It is a streaming block with ivalid-only input and no backpressure. Frame boundaries come from ilast or from a frame-length limit.

Parameters:
WIDTH_A, 12, signed width of dataa_r and dataa_i
WIDTH_B, 12, signed width of datab_r and datab_i
WIDTH_O, 16, signed width of result_r and result_i
SHIFT, 0, arithmetic right shift applied before the output saturation (0..ACC_W-1)
ROUND, 1, 1 = round half up (add 2^(SHIFT-1) before the shift), 0 = truncate; ignored when SHIFT=0
ACC_GUARD, 8, accumulator guard bits; ACC_W = WIDTH_A+WIDTH_B+1+ACC_GUARD
CNT_WIDTH, 8, frame-length counter width; maximum frame length = 2^CNT_WIDTH samples

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
ivalid  in  1  input sample valid
ilast  in  1  last sample of frame; qualified by ivalid; ignored in multiply mode
acc_en  in  1  0 = multiply mode, 1 = accumulate mode; sampled on the first sample of each frame
conj_b  in  1  1 = use conj(B); sampled on every valid sample
dataa_r, dataa_i  in  WIDTH_A  operand A, signed
datab_r, datab_i  in  WIDTH_B  operand B, signed
ovalid  out  1  one-cycle pulse, result valid
result_r, result_i  out  WIDTH_O  scaled, saturated result
ocount  out  CNT_WIDTH+1  number of samples in the emitted frame
osat  out  1  1 = saturation occurred in this result or frame (accumulator or output)

Behaviour:
- Reset: all pipeline registers, the accumulator, the counter, ovalid, result_r, result_i, ocount and osat go to 0. Frame state goes to IDLE, so the next valid sample is a frame start. A reset mid-frame discards the partial frame and any in-flight samples.
- Stage 1 (registered on ivalid): rr=ar*br, ii=ai*bi, ri=ar*bi, ir=ai*br, each full width. conj_b and the frame flags are pipelined alongside.
- Stage 2: re = rr - ii, im = ri + ir; when conj_b=1, re = rr + ii, im = ir - ri. Width is WIDTH_A+WIDTH_B+1, so no overflow is possible at this stage.
- Stage 3: accumulate or pass, then scale and round, then saturate, into output registers.
- Latency: ovalid rises exactly 3 cycles after the ivalid that carries the product (multiply mode) or the frame's final sample (accumulate mode). Gaps in ivalid insert no extra latency and produce no spurious ovalid.
- Frame FSM, states IDLE / ACC:
  - IDLE + ivalid: latch acc_en as the frame mode.
  - Multiply mode: emit every sample with ocount=1, stay in IDLE.
  - Accumulate mode: load acc = product, count = 1. If ilast or the limit is reached, emit and stay in IDLE; otherwise go to ACC.
  - ACC + ivalid: acc += product, count += 1. Emit and return to IDLE when ilast=1 or count reaches 2^CNT_WIDTH (forced emit).
  - acc_en changes mid-frame are ignored until the next frame.
- The accumulator is ACC_W signed and saturates at ±limit instead of wrapping. A saturation event sets a frame-sticky flag that is cleared at frame start.
- Output scaling: v = (ROUND && SHIFT>0) ? (S + 2^(SHIFT-1)) >>> SHIFT : S >>> SHIFT. Then clamp to [-2^(WIDTH_O-1), 2^(WIDTH_O-1)-1].
- osat = output clamp on re or im OR the frame-sticky accumulator saturation.
- Outputs hold their last value between ovalid pulses.
- A frame emit and the next frame's first sample may arrive on consecutive cycles. This must work back-to-back with no lost sample and no extra cycle.

Test Plan:
1. Multiply mode, SHIFT=0: A=3+4j, B=1+2j, conj_b=0 -> 3 cycles later ovalid=1, result=-5+10j, ocount=1, osat=0. The same inputs with conj_b=1 -> 11-2j.
2. Accumulate mode: 4 consecutive samples of A=100+0j, B=100+0j, ilast on the 4th -> single ovalid 3 cycles after the 4th sample. Sum 40000 clamps to 32767+0j with osat=1 and ocount=4.
3. SHIFT=2, ROUND=1, multiply A=3+4j, B=1+2j -> result -1+3j. With ROUND=0 -> result -2+2j.
4. CNT_WIDTH=3, accumulate with ilast never asserted, 10 samples of 1+1j * 1+0j -> forced emit after sample 8 with 8+8j and ocount=8. The next frame starts at sample 9 and continues.
5. Back-to-back frames of length 1 and 2 in accumulate mode, ivalid held continuously, acc_en toggled mid-frame -> exactly 2 results with correct sums; the mid-frame toggle has no effect.
6. Assert reset during an accumulate frame after 3 samples, release, then send one frame (2,0)*(3,0) with ilast -> output 6+0j with ocount=1. No output is emitted for the aborted frame.

Source files
------------

// File: rtl/cmpl_mult_acc.sv
// Streaming complex multiplier with optional per-frame complex accumulation,
// optional conj(B), round/shift scaling and output saturation. Latency is 3 cycles.
module cmpl_mult_acc #(
  parameter int WIDTH_A   = 12,
  parameter int WIDTH_B   = 12,
  parameter int WIDTH_O   = 16,
  parameter int SHIFT     = 0,
  parameter int ROUND     = 1,
  parameter int ACC_GUARD = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ivalid,
  input  logic                 ilast,
  input  logic                 acc_en,
  input  logic                 conj_b,
  input  logic [WIDTH_A-1:0]   dataa_r,
  input  logic [WIDTH_A-1:0]   dataa_i,
  input  logic [WIDTH_B-1:0]   datab_r,
  input  logic [WIDTH_B-1:0]   datab_i,
  output logic                 ovalid,
  output logic [WIDTH_O-1:0]   result_r,
  output logic [WIDTH_O-1:0]   result_i,
  output logic [CNT_WIDTH:0]   ocount,
  output logic                 osat
);

  // state  | meaning
  // S_IDLE | no open frame; next valid sample starts a frame (mode latched then)
  // S_ACC  | accumulate frame open; samples add until ilast or the length limit

  localparam int PROD_W = WIDTH_A + WIDTH_B;
  localparam int SUM_W  = PROD_W + 1;
  localparam int ACC_W  = SUM_W + ACC_GUARD;

  localparam logic [CNT_WIDTH:0] CNT_ONE = {{CNT_WIDTH{1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH:0] CNT_MAX = CNT_ONE << CNT_WIDTH;

  // Accumulator lives in ACC_W+1 bits so the add never wraps before the clamp.
  localparam logic signed [ACC_W:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W:0] ACC_ONE = {{ACC_W{1'b0}}, 1'b1};
  localparam logic signed [ACC_W:0] RND     = (ROUND != 0) ? ((ACC_ONE << SHIFT) >> 1) : '0;

  localparam logic signed [ACC_W:0] OUT_MAX_X = {{(ACC_W+2-WIDTH_O){1'b0}}, {(WIDTH_O-1){1'b1}}};
  localparam logic signed [ACC_W:0] OUT_MIN_X = {{(ACC_W+2-WIDTH_O){1'b1}}, {(WIDTH_O-1){1'b0}}};
  localparam logic [WIDTH_O-1:0]    OUT_MAX   = {1'b0, {(WIDTH_O-1){1'b1}}};
  localparam logic [WIDTH_O-1:0]    OUT_MIN   = {1'b1, {(WIDTH_O-1){1'b0}}};

  typedef enum logic {S_IDLE, S_ACC} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH:0]   r_cnt;
  logic [CNT_WIDTH:0]   w_cnt;
  logic                 w_first;
  logic                 w_emit;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt       = r_cnt;
    w_first     = 1'b0;
    w_emit      = 1'b0;
    if (ivalid) begin
      if (r_state == S_IDLE) begin
        w_first = 1'b1;
        w_cnt   = CNT_ONE;
        w_emit  = !acc_en || ilast || (CNT_ONE == CNT_MAX);
      end else begin
        w_cnt   = r_cnt + CNT_ONE;
        w_emit  = ilast || (w_cnt == CNT_MAX);
      end
      w_state_nxt = w_emit ? S_IDLE : S_ACC;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt;
    end
  end

  // Stage 1: four partial products at full width.
  logic signed [PROD_W-1:0] w_ar_x, w_ai_x, w_br_x, w_bi_x;
  assign w_ar_x = {{WIDTH_B{dataa_r[WIDTH_A-1]}}, dataa_r};
  assign w_ai_x = {{WIDTH_B{dataa_i[WIDTH_A-1]}}, dataa_i};
  assign w_br_x = {{WIDTH_A{datab_r[WIDTH_B-1]}}, datab_r};
  assign w_bi_x = {{WIDTH_A{datab_i[WIDTH_B-1]}}, datab_i};

  logic signed [PROD_W-1:0] r_rr, r_ii, r_ri, r_ir;
  logic                     r_v1, r_conj1, r_first1, r_emit1;
  logic [CNT_WIDTH:0]       r_cnt1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr     <= '0;
      r_ii     <= '0;
      r_ri     <= '0;
      r_ir     <= '0;
      r_v1     <= 1'b0;
      r_conj1  <= 1'b0;
      r_first1 <= 1'b0;
      r_emit1  <= 1'b0;
      r_cnt1   <= '0;
    end else begin
      r_v1 <= ivalid;
      if (ivalid) begin
        r_rr     <= w_ar_x * w_br_x;
        r_ii     <= w_ai_x * w_bi_x;
        r_ri     <= w_ar_x * w_bi_x;
        r_ir     <= w_ai_x * w_br_x;
        r_conj1  <= conj_b;
        r_first1 <= w_first;
        r_emit1  <= w_emit;
        r_cnt1   <= w_cnt;
      end
    end
  end

  // Stage 2: combine into the complex product; one growth bit makes it exact.
  logic signed [SUM_W-1:0] w_rr_x, w_ii_x, w_ri_x, w_ir_x, w_re, w_im;
  assign w_rr_x = {r_rr[PROD_W-1], r_rr};
  assign w_ii_x = {r_ii[PROD_W-1], r_ii};
  assign w_ri_x = {r_ri[PROD_W-1], r_ri};
  assign w_ir_x = {r_ir[PROD_W-1], r_ir};
  assign w_re   = r_conj1 ? (w_rr_x + w_ii_x) : (w_rr_x - w_ii_x);
  assign w_im   = r_conj1 ? (w_ir_x - w_ri_x) : (w_ri_x + w_ir_x);

  logic signed [SUM_W-1:0] r_re2, r_im2;
  logic                    r_v2, r_first2, r_emit2;
  logic [CNT_WIDTH:0]      r_cnt2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_re2    <= '0;
      r_im2    <= '0;
      r_v2     <= 1'b0;
      r_first2 <= 1'b0;
      r_emit2  <= 1'b0;
      r_cnt2   <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_re2    <= w_re;
        r_im2    <= w_im;
        r_first2 <= r_first1;
        r_emit2  <= r_emit1;
        r_cnt2   <= r_cnt1;
      end
    end
  end

  // Stage 3: a frame's first sample loads, later samples add with saturation.
  logic signed [ACC_W:0] r_acc_r, r_acc_i;
  logic                  r_sticky;
  logic signed [ACC_W:0] w_re_x, w_im_x, w_base_r, w_base_i, w_add_r, w_add_i;
  logic signed [ACC_W:0] w_acc_r, w_acc_i;
  logic                  w_asat_r, w_asat_i, w_sticky;

  assign w_re_x   = {{(ACC_W+1-SUM_W){r_re2[SUM_W-1]}}, r_re2};
  assign w_im_x   = {{(ACC_W+1-SUM_W){r_im2[SUM_W-1]}}, r_im2};
  assign w_base_r = r_first2 ? '0 : r_acc_r;
  assign w_base_i = r_first2 ? '0 : r_acc_i;
  assign w_add_r  = w_base_r + w_re_x;
  assign w_add_i  = w_base_i + w_im_x;

  always_comb begin
    w_acc_r  = w_add_r;
    w_asat_r = 1'b0;
    if (w_add_r > ACC_MAX) begin
      w_acc_r  = ACC_MAX;
      w_asat_r = 1'b1;
    end else if (w_add_r < ACC_MIN) begin
      w_acc_r  = ACC_MIN;
      w_asat_r = 1'b1;
    end
  end

  always_comb begin
    w_acc_i  = w_add_i;
    w_asat_i = 1'b0;
    if (w_add_i > ACC_MAX) begin
      w_acc_i  = ACC_MAX;
      w_asat_i = 1'b1;
    end else if (w_add_i < ACC_MIN) begin
      w_acc_i  = ACC_MIN;
      w_asat_i = 1'b1;
    end
  end

  assign w_sticky = (r_first2 ? 1'b0 : r_sticky) | w_asat_r | w_asat_i;

  // Scaling works on the freshly updated accumulator, so the emit needs no extra cycle.
  logic signed [ACC_W:0] w_rnd_r, w_rnd_i, w_shr_r, w_shr_i;
  logic                  w_hi_r, w_lo_r, w_hi_i, w_lo_i;

  assign w_rnd_r = w_acc_r + RND;
  assign w_rnd_i = w_acc_i + RND;
  assign w_shr_r = w_rnd_r >>> SHIFT;
  assign w_shr_i = w_rnd_i >>> SHIFT;
  assign w_hi_r  = w_shr_r > OUT_MAX_X;
  assign w_lo_r  = w_shr_r < OUT_MIN_X;
  assign w_hi_i  = w_shr_i > OUT_MAX_X;
  assign w_lo_i  = w_shr_i < OUT_MIN_X;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc_r  <= '0;
      r_acc_i  <= '0;
      r_sticky <= 1'b0;
      ovalid   <= 1'b0;
      result_r <= '0;
      result_i <= '0;
      ocount   <= '0;
      osat     <= 1'b0;
    end else begin
      ovalid <= r_v2 && r_emit2;
      if (r_v2) begin
        r_acc_r  <= w_acc_r;
        r_acc_i  <= w_acc_i;
        r_sticky <= w_sticky;
      end
      if (r_v2 && r_emit2) begin
        result_r <= w_hi_r ? OUT_MAX : (w_lo_r ? OUT_MIN : w_shr_r[WIDTH_O-1:0]);
        result_i <= w_hi_i ? OUT_MAX : (w_lo_i ? OUT_MIN : w_shr_i[WIDTH_O-1:0]);
        ocount   <= r_cnt2;
        osat     <= w_hi_r | w_lo_r | w_hi_i | w_lo_i | w_sticky;
      end
    end
  end

endmodule
